// File: rtl/mmio_interconnect.sv
// mmio_interconnect: base/size decoded cpu-to-slave bridge with a registered req/ready handshake and sticky error log.
// Optional feature macro MMIO_TIMEOUT_EN adds an ACCESS watchdog that aborts stalled slaves with an error response.
module mmio_interconnect #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 8,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h2000, 32'h1000, 32'h0, 32'h0},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = {32'h4, 32'h1000, 32'h1000, 32'h0},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         m_req,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic                         m_we,
    input  logic [DATA_W-1:0]            m_wdata,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [ADDR_W-1:0]            s_addr,
    output logic                         s_we,
    output logic [DATA_W-1:0]            s_wdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    output logic                         err_valid,
    output logic [ADDR_W-1:0]            err_addr,
    input  logic                         err_clr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [NUM_SLAVES-1:0]   sel_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic                    we_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [DATA_W-1:0]       rdata_reg;
    logic                    err_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic                    err_valid_reg;
    logic [ADDR_W-1:0]       err_addr_reg;

    logic [NUM_SLAVES-1:0]   hit;
    logic [ADDR_W-1:0]       offset [NUM_SLAVES];
    logic                    any_hit;
    logic [IDX_W-1:0]        hit_idx;
    logic [ADDR_W-1:0]       hit_offset;
    logic [NUM_SLAVES-1:0]   hit_onehot;
    logic                    slave_done;
    logic [DATA_W-1:0]       slave_data;
    logic                    unmapped_req;
    logic                    new_err;
    logic [ADDR_W-1:0]       new_err_addr;

    // Limit is computed one bit wider so a window touching the top of the address space never wraps.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
            localparam logic [ADDR_W-1:0] BASE  = SLAVE_BASE[gi*ADDR_W +: ADDR_W];
            localparam logic [ADDR_W-1:0] SIZE  = SLAVE_SIZE[gi*ADDR_W +: ADDR_W];
            localparam logic [ADDR_W:0]   LIMIT = {1'b0, BASE} + {1'b0, SIZE};
            assign hit[gi]    = (SIZE != '0) && (m_addr >= BASE) && ({1'b0, m_addr} < LIMIT);
            assign offset[gi] = m_addr - BASE;
        end
    endgenerate

    // Descending scan: the last match written is the lowest index, which wins on overlap.
    always_comb begin
        any_hit    = 1'b0;
        hit_idx    = '0;
        hit_offset = '0;
        hit_onehot = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit       = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_offset    = offset[i];
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        slave_done = 1'b0;
        slave_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                slave_done = s_ready[i];
                slave_data = s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign unmapped_req = (state_reg == IDLE) && m_req && !any_hit;

`ifdef MMIO_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic              tmo_expire;

    // A slave answering on the expiry cycle still completes normally.
    assign tmo_expire = (state_reg == ACCESS) && !slave_done
                        && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_reg  <= '0;
            req_addr_reg <= '0;
        end else begin
            if (state_reg == ACCESS && !slave_done && !tmo_expire)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            else
                tmo_cnt_reg <= '0;
            if (state_reg == IDLE && m_req && any_hit)
                req_addr_reg <= m_addr;
        end
    end

    assign new_err      = unmapped_req || tmo_expire;
    assign new_err_addr = tmo_expire ? req_addr_reg : m_addr;
`else
    assign new_err      = unmapped_req;
    assign new_err_addr = m_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (m_req) state_next = any_hit ? ACCESS : RESP;
            end
            ACCESS: begin
                if (slave_done) state_next = RESP;
`ifdef MMIO_TIMEOUT_EN
                else if (tmo_expire) state_next = RESP;
`endif
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg   <= '0;
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m_req && any_hit) begin
                        sel_reg   <= hit_onehot;
                        addr_reg  <= hit_offset;
                        we_reg    <= m_we;
                        wdata_reg <= m_wdata;
                        idx_reg   <= hit_idx;
                    end else if (m_req) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (slave_done) begin
                        sel_reg   <= '0;
                        rdata_reg <= we_reg ? '0 : slave_data;
                        err_reg   <= 1'b0;
                    end
`ifdef MMIO_TIMEOUT_EN
                    else if (tmo_expire) begin
                        sel_reg   <= '0;
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // A clear coinciding with a new error loses: the new error is logged as the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
        end else if (new_err) begin
            err_valid_reg <= 1'b1;
            if (!err_valid_reg || err_clr) err_addr_reg <= new_err_addr;
        end else if (err_clr) begin
            err_valid_reg <= 1'b0;
            err_addr_reg  <= '0;
        end
    end

    assign m_ready   = (state_reg == RESP);
    assign m_err     = (state_reg == RESP) && err_reg;
    assign m_rdata   = rdata_reg;
    assign s_sel     = sel_reg;
    assign s_addr    = addr_reg;
    assign s_we      = we_reg;
    assign s_wdata   = wdata_reg;
    assign err_valid = err_valid_reg;
    assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_mmio_interconnect.sv
// Self-checking bench for mmio_interconnect: directed and random transactions against an address-map model.
module tb_mmio_interconnect;

    localparam int TMO = 16;
    localparam logic [127:0] SB = {32'h0000_0F00, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [127:0] SS = {32'h0000_0200, 32'h0000_0004, 32'h0000_1000, 32'h0000_1000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_req = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_we = 1'b0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_rdata;
    logic        m_ready;
    logic        m_err;
    logic [3:0]  s_sel;
    logic [31:0] s_addr;
    logic        s_we;
    logic [7:0]  s_wdata;
    logic [31:0] s_rdata;
    logic [3:0]  s_ready;
    logic        err_valid;
    logic [31:0] err_addr;
    logic        err_clr = 1'b0;

    int total = 0;
    int bad = 0;

    // Address map model (same windows as SB/SS; slot3 overlaps slots 0 and 1)
    longint t_base [4] = '{64'h0, 64'h1000, 64'h2000, 64'h0F00};
    longint t_size [4] = '{64'h1000, 64'h1000, 64'h4, 64'h200};
    bit          exp_ev = 1'b0;
    logic [31:0] exp_ea = '0;

    // Slave behaviour: selected slot answers after wait_cycles ACCESS cycles (-1 never)
    logic [7:0] slave_data [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    logic [3:0] noise = '0;
    int         wait_cycles = 0;
    int         acc_cnt = 0;

    mmio_interconnect #(
        .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(8),
        .SLAVE_BASE(SB), .SLAVE_SIZE(SS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err), .s_sel(s_sel), .s_addr(s_addr),
        .s_we(s_we), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready),
        .err_valid(err_valid), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) acc_cnt <= (s_sel != 4'b0) ? acc_cnt + 1 : 0;

    always_comb begin
        s_ready = noise & ~s_sel;
        if (acc_cnt == wait_cycles) s_ready = s_ready | s_sel;
        for (int i = 0; i < 4; i++) s_rdata[i*8 +: 8] = slave_data[i];
    end

    function automatic int model_slot(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if (t_size[i] != 0 && longint'(a) >= t_base[i] && longint'(a) < t_base[i] + t_size[i])
                return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_log();
        check("err_valid", 64'(err_valid), 64'(exp_ev));
        check("err_addr", 64'(err_addr), 64'(exp_ea));
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [7:0] wd,
                          input int waits, input logic [7:0] rd_val, input bit clr);
        int slot;
        int exp_cyc;
        bit exp_err;
        bit tmo;
        bit got;
        int c;
        logic [7:0]  exp_rd;
        logic [31:0] exp_off;
        logic [3:0]  exp_sel;
        slot = model_slot(addr);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) slave_data[i] = 8'($urandom);
        if (slot >= 0) slave_data[slot] = rd_val;
        noise = 4'($urandom);
        wait_cycles = waits;
        m_req = 1'b1; m_addr = addr; m_we = we; m_wdata = wd; err_clr = clr;
        tmo = 1'b0;
        exp_off = '0;
        exp_sel = '0;
        if (slot < 0) begin
            exp_cyc = 1; exp_err = 1'b1; exp_rd = '0;
        end else begin
`ifdef MMIO_TIMEOUT_EN
            if (waits < 0 || waits >= TMO) tmo = 1'b1;
`endif
            exp_cyc = tmo ? 1 + TMO : 2 + waits;
            exp_err = tmo;
            exp_rd  = (we || tmo) ? 8'h00 : rd_val;
            exp_off = addr - 32'(t_base[slot]);
            exp_sel = 4'b0001 << slot;
        end
        if (clr) begin exp_ev = 1'b0; exp_ea = '0; end
        if ((slot < 0 || tmo) && !exp_ev) begin exp_ev = 1'b1; exp_ea = addr; end
        got = 1'b0;
        for (c = 1; c <= exp_cyc + 4 && !got; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                m_req = 1'b0; m_addr = $urandom; m_we = 1'($urandom); m_wdata = 8'($urandom); err_clr = 1'b0;
            end
            @(negedge clk);
            if (m_ready) got = 1'b1;
            if (c < exp_cyc) begin
                check("early_ready", 64'(m_ready), 64'd0);
                if (slot >= 0) begin
                    check("s_sel", 64'(s_sel), 64'(exp_sel));
                    check("s_addr", 64'(s_addr), 64'(exp_off));
                    check("s_we", 64'(s_we), 64'(we));
                    check("s_wdata", 64'(s_wdata), 64'(wd));
                end
            end else if (c == exp_cyc) begin
                check("m_ready", 64'(m_ready), 64'd1);
                check("m_err", 64'(m_err), 64'(exp_err));
                check("m_rdata", 64'(m_rdata), 64'(exp_rd));
                check("sel_in_resp", 64'(s_sel), 64'd0);
            end
        end
        if (!got) check("ready_bound", 64'(got), 64'd1);
        $display("txn addr=%08h we=%0d wdata=%02h waits=%0d clr=%0d slot=%0d cycles=%0d rdata=%02h err=%0d",
                 addr, we, wd, waits, clr, slot, c - 1, m_rdata, m_err);
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_pulse", 64'(m_ready), 64'd0);
        check("sel_idle", 64'(s_sel), 64'd0);
        check("rdata_hold", 64'(m_rdata), 64'(exp_rd));
        check_log();
    endtask

    task automatic check_reset_outputs();
        check("rst_m_rdata", 64'(m_rdata), 64'd0);
        check("rst_m_ready", 64'(m_ready), 64'd0);
        check("rst_m_err", 64'(m_err), 64'd0);
        check("rst_s_sel", 64'(s_sel), 64'd0);
        check("rst_s_addr", 64'(s_addr), 64'd0);
        check("rst_s_we", 64'(s_we), 64'd0);
        check("rst_s_wdata", 64'(s_wdata), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_err_addr", 64'(err_addr), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed scenarios
        do_txn(32'h0000_0010, 1'b0, 8'h00, 0, 8'hA5, 1'b0);
        do_txn(32'h0000_1004, 1'b1, 8'h3C, 3, 8'h77, 1'b0);
        do_txn(32'h0000_5000, 1'b0, 8'h00, 0, 8'h00, 1'b0);
        do_txn(32'h0000_6000, 1'b0, 8'h00, 0, 8'h00, 1'b0);
        do_txn(32'h0000_0FFF, 1'b0, 8'h00, 1, 8'h5A, 1'b0);
        do_txn(32'h0000_1000, 1'b0, 8'h00, 0, 8'hC3, 1'b0);
        do_txn(32'h0000_0F80, 1'b0, 8'h00, 2, 8'h11, 1'b0);
        do_txn(32'h0000_2003, 1'b0, 8'h00, 0, 8'h99, 1'b0);
        do_txn(32'h0000_2004, 1'b0, 8'h00, 0, 8'h00, 1'b0);
        do_txn(32'hFFFF_FFFF, 1'b1, 8'hEE, 0, 8'h00, 1'b0);

        // Standalone clear, then clear coinciding with a new error
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        exp_ev = 1'b0; exp_ea = '0;
        @(negedge clk);
        check_log();
        do_txn(32'h0000_7000, 1'b0, 8'h00, 0, 8'h00, 1'b0);
        do_txn(32'h0000_8000, 1'b0, 8'h00, 0, 8'h00, 1'b1);
        do_txn(32'h0000_0020, 1'b0, 8'h00, 0, 8'h42, 1'b1);

`ifdef MMIO_TIMEOUT_EN
        do_txn(32'h0000_2001, 1'b0, 8'h00, -1, 8'h66, 1'b0);
        do_txn(32'h0000_2002, 1'b0, 8'h00, TMO - 1, 8'h67, 1'b0);
`endif

        // Reset during ACCESS: no completion pulse, everything back to reset values
        @(posedge clk); #1;
        wait_cycles = 5; noise = '0;
        m_req = 1'b1; m_addr = 32'h0000_1010; m_we = 1'b0;
        @(posedge clk); #1; m_req = 1'b0;
        @(negedge clk);
        check("mid_sel", 64'(s_sel), 64'b0010);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_ev = 1'b0; exp_ea = '0;
        @(negedge clk);
        check_reset_outputs();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("no_ready_after_rst", 64'(m_ready), 64'd0);
        end
        $display("txn reset during ACCESS at addr=00001010");
        do_txn(32'h0000_1010, 1'b0, 8'h00, 1, 8'h4D, 1'b0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = 32'($urandom_range(0, 32'hFFF));
                1:       ra = 32'h1000 + 32'($urandom_range(0, 32'hFFF));
                2:       ra = 32'h2000 + 32'($urandom_range(0, 7));
                default: ra = $urandom;
            endcase
            do_txn(ra, 1'($urandom), 8'($urandom), int'($urandom_range(0, 4)), 8'($urandom),
                   $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
